// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - instruction cache line refill controller
module icache_refill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   pc_addr,
    input  logic                cache_hit,
    input  logic [WORD_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [4*WORD_W-1:0] line_data,
    output logic                line_valid,
    output logic                stall,
    output logic [CNT_W-1:0]    miss_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WRITE  = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        cnt;
    logic [ADDR_W-4:0] base_line;
    logic              miss;
    logic              capture;

    assign miss    = (state == IDLE) && !cache_hit;
    assign capture = (state == REQ) && mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!cache_hit) next_state = REQ;
            REQ:     if (mem_ready && cnt == 2'd3) next_state = WRITE;
            WRITE:   next_state = SETTLE;
            SETTLE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        stall = (state != IDLE) || !cache_hit;
    end

    // Request and write strobe are registered from next_state so they are
    // glitch-free and line up exactly with the REQ and WRITE states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 2'd0;
            base_line  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            line_data  <= '0;
            line_valid <= 1'b0;
            miss_count <= '0;
        end else begin
            mem_req    <= (next_state == REQ);
            line_valid <= (next_state == WRITE);
            if (miss) begin
                base_line <= pc_addr[ADDR_W-1:3];
                cnt       <= 2'd0;
                mem_addr  <= {pc_addr[ADDR_W-1:3], 3'b000};
            end
            if (capture) begin
                for (int k = 0; k < 4; k++) begin
                    if (cnt == k[1:0]) begin
                        line_data[k*WORD_W +: WORD_W] <= mem_rdata;
                    end
                end
                if (cnt != 2'd3) begin
                    cnt      <= cnt + 2'd1;
                    mem_addr <= {base_line, cnt + 2'd1, 1'b0};
                end
            end
            if (state == WRITE && miss_count != '1) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - randomized scoreboard bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_addr;
    logic        cache_hit;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [63:0] line_data;
    logic        line_valid;
    logic        stall;
    logic [15:0] miss_count;

    logic        s_mem_req;
    logic [15:0] s_mem_addr;
    logic [63:0] s_line_data;
    logic        s_line_valid;
    logic        s_stall;
    logic [1:0]  s_miss_count;

    icache_refill_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .cache_hit(cache_hit),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_addr(mem_addr), .line_data(line_data), .line_valid(line_valid),
        .stall(stall), .miss_count(miss_count)
    );

    icache_refill_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .cache_hit(cache_hit),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(s_mem_req),
        .mem_addr(s_mem_addr), .line_data(s_line_data), .line_valid(s_line_valid),
        .stall(s_stall), .miss_count(s_miss_count)
    );

    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          hs_cnt = 0;
    int          model_cnt = 0;
    int          lat_sum = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    int          wait_left = 0;
    bit          pending = 0;
    bit          spurious = 0;
    bit          prev_lv = 0;
    logic [15:0] salt = 16'h0000;
    logic [63:0] exp_line[$];
    logic [15:0] exp_addr[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {1'b0, a[15:1]} ^ salt;
    endfunction

    function automatic logic [63:0] model_line(input logic [15:0] b);
        logic [63:0] l;
        for (int k = 0; k < 4; k++) l[16*k +: 16] = word_at(b + 16'(2*k));
        return l;
    endfunction

    // Instruction memory: variable latency per request, optional noise on mem_ready while idle.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (!pending) begin
                pending   = 1'b1;
                wait_left = $urandom_range(lat_hi, lat_lo);
                lat_sum  += wait_left + 1;
            end
            if (wait_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = word_at(mem_addr);
                pending   = 1'b0;
            end else begin
                mem_ready = 1'b0;
                wait_left--;
            end
        end else begin
            pending   = 1'b0;
            mem_ready = spurious ? 1'($urandom % 2) : 1'b0;
            mem_rdata = 16'($urandom);
        end
    end

    // Monitor: pops expected addresses on each handshake and expected lines on each strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req && mem_ready) begin
                hs_cnt++;
                if (exp_addr.size() == 0) chk("unexpected_mem_handshake", 64'(mem_addr), 64'hDEAD);
                else chk("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
            end
            if (line_valid) begin
                chk("line_valid_single_cycle", 64'(prev_lv), 64'd0);
                chk("mem_req_low_in_write", 64'(mem_req), 64'd0);
                if (exp_line.size() == 0) chk("unexpected_line_valid", line_data, 64'hDEAD);
                else begin
                    chk("line_data", line_data, exp_line.pop_front());
                    model_cnt++;
                end
            end
            prev_lv = line_valid;
        end else begin
            prev_lv = 1'b0;
        end
    end

    task automatic issue_miss(input logic [15:0] a, input int lo, input int hi);
        logic [15:0] b;
        lat_lo  = lo;
        lat_hi  = hi;
        lat_sum = 0;
        b = {a[15:3], 3'b000};
        exp_line.push_back(model_line(b));
        for (int k = 0; k < 4; k++) exp_addr.push_back(b + 16'(2*k));
        pc_addr   = a;
        cache_hit = 1'b0;
    endtask

    task automatic do_miss(input logic [15:0] a, input int lo, input int hi,
                           input bit chg, input logic [15:0] a2);
        int  n;
        int  hs0;
        bit  done;
        @(negedge clk);
        hs0 = hs_cnt;
        issue_miss(a, lo, hi);
        n    = 0;
        done = 0;
        while (!done) begin
            #1;
            if (!stall) done = 1;
            else begin
                n++;
                if (n > 100) begin
                    chk("stall_timeout", 64'(n), 64'd0);
                    done = 1;
                end else begin
                    if (chg && hs_cnt - hs0 == 2) pc_addr = a2;
                    if (line_valid) cache_hit = 1'b1;
                    @(negedge clk);
                end
            end
        end
        chk("stall_cycles", 64'(n), 64'(3 + lat_sum));
        chk("miss_count", 64'(miss_count), 64'(model_cnt));
        chk("miss_count_sat", 64'(s_miss_count), 64'(model_cnt > 3 ? 3 : model_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs0;
        int guard;
        rst_n     = 1'b0;
        pc_addr   = 16'h0000;
        cache_hit = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_line_data", line_data, 64'd0);
        chk("rst_line_valid", 64'(line_valid), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);
        chk("rst_stall_hit", 64'(stall), 64'd0);
        cache_hit = 1'b0;
        #1;
        chk("rst_stall_miss", 64'(stall), 64'd1);
        cache_hit = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait memory, words 0..3
        do_miss(16'h0000, 0, 0, 0, 16'h0);
        chk("t1_line_const", line_data, 64'h0003000200010000);
        // Two-cycle memory at pc 0x000A
        do_miss(16'h000A, 1, 1, 0, 16'h0);
        chk("t2_line_const", line_data, 64'h0007000600050004);
        // PC moves away mid-refill
        do_miss(16'h0012, 0, 2, 1, 16'h0400);

        // Reset after two words
        @(negedge clk);
        hs0 = hs_cnt;
        issue_miss(16'h0120, 0, 1);
        guard = 0;
        while (hs_cnt - hs0 < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("reset_wait_two_words", 64'(hs_cnt - hs0), 64'd2);
        #2;
        rst_n     = 1'b0;
        cache_hit = 1'b1;
        #1;
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("midrst_line_data", line_data, 64'd0);
        chk("midrst_line_valid", 64'(line_valid), 64'd0);
        chk("midrst_miss_count", 64'(miss_count), 64'd0);
        chk("midrst_stall", 64'(stall), 64'd0);
        exp_line.delete();
        exp_addr.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Spurious mem_ready while idle with hits
        spurious = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pc_addr = 16'($urandom);
            @(negedge clk);
            #1;
            chk("spur_mem_req", 64'(mem_req), 64'd0);
            chk("spur_line_valid", 64'(line_valid), 64'd0);
            chk("spur_stall", 64'(stall), 64'd0);
            chk("spur_line_data", line_data, 64'd0);
        end
        spurious = 1'b0;
        chk("spur_miss_count", 64'(miss_count), 64'd0);

        // Top-of-memory line
        do_miss(16'hFFFC, 0, 0, 0, 16'h0);
        chk("top_line_const", line_data, 64'h7FFF7FFE7FFD7FFC);

        // Randomized refills
        for (int i = 0; i < 20; i++) begin
            salt = 16'($urandom);
            do_miss(16'($urandom), 0, 3, 1'($urandom % 2), 16'($urandom));
        end
        chk("final_sat_holds", 64'(s_miss_count), 64'd3);
        repeat (3) @(negedge clk);
        chk("exp_line_drained", 64'(exp_line.size()), 64'd0);
        chk("exp_addr_drained", 64'(exp_addr.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
